shift_arbiter: RTL and testbench

Arbitrates the single shared 32-bit arithmetic right shifter between two requesters (requester 0: CPU execute stage; requester 1: board row-clear/drop engine) and sequences the shifter through one or two passes per operation. Each operation is accepted over a valid/ready request channel, executed on the shared shifter, registered, and returned over one shared valid/ready response channel tagged with the requester ID. The shifter stays combinational and is instantiated once inside this block.

---
 rtl/shift_arbiter_if.sv | 32 +++
 rtl/shift_arbiter.sv | 117 +++++++++++
 tb/tb_shift_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: two valid/ready request channels in, one tagged valid/ready response out.
interface shift_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_data;
   logic [4:0]  req0_amt;
   logic        req0_logical;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_data;
   logic [4:0]  req1_amt;
   logic        req1_logical;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_id;
   logic        busy;

   modport master (
      output req0_valid, req0_data, req0_amt, req0_logical,
      output req1_valid, req1_data, req1_amt, req1_logical,
      output rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req0_valid, req0_data, req0_amt, req0_logical,
      input  req1_valid, req1_data, req1_amt, req1_logical,
      input  rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit arithmetic right shifter; accept N -> rsp_valid N+2 (N+3 logical).
// Response held in RESP until rsp_ready; no accept outside IDLE. SHIFT_ARB_LOGICAL_EN adds the logical-shift mask pass.
module shift_arbiter (
   input  logic           clk,
   input  logic           rst,
   shift_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
`ifdef SHIFT_ARB_LOGICAL_EN
      MASK  = 2'd1,
`endif
      SHIFT = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state, nxt;
   logic        last;
   logic        sel;
   logic        accept;
   logic [31:0] op_data;
   logic [4:0]  op_amt;
   logic        op_id;
   logic [31:0] rsp_data;
   logic [31:0] mask;
   logic [31:0] sh_in;
   logic [31:0] sh_out;
   logic        sel_logical;

   // The one shared shifter; MASK reuses it to build the zero-fill mask.
   assign sh_out = 32'($signed(sh_in) >>> op_amt);

`ifdef SHIFT_ARB_LOGICAL_EN
   logic op_logical;
   assign sel_logical = sel ? bus.req1_logical : bus.req0_logical;
`else
   logic unused_logical;
   assign unused_logical = bus.req0_logical ^ bus.req1_logical;
   assign sel_logical    = 1'b0;
   assign mask           = '1;
`endif

   always_comb begin
      sel    = bus.req1_valid;
      accept = 1'b0;
      nxt    = state;
      sh_in  = op_data;
      if (bus.req0_valid && bus.req1_valid)
         sel = ~last;
      case (state)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               accept = 1'b1;
`ifdef SHIFT_ARB_LOGICAL_EN
               nxt    = sel_logical ? MASK : SHIFT;
`else
               nxt    = SHIFT;
`endif
            end
         end
`ifdef SHIFT_ARB_LOGICAL_EN
         MASK: begin
            sh_in = 32'h8000_0000;
            nxt   = SHIFT;
         end
`endif
         SHIFT: nxt = RESP;
         RESP:  if (bus.rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         op_data  <= '0;
         op_amt   <= '0;
         op_id    <= 1'b0;
         rsp_data <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            last    <= sel;
            op_id   <= sel;
            op_data <= sel ? bus.req1_data : bus.req0_data;
            op_amt  <= sel ? bus.req1_amt : bus.req0_amt;
         end
         if (state == SHIFT)
            rsp_data <= sh_out & mask;
      end
   end

`ifdef SHIFT_ARB_LOGICAL_EN
   // Arithmetic ops must see an all-ones mask, so every accept restores it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask       <= '1;
         op_logical <= 1'b0;
      end else if (accept) begin
         mask       <= '1;
         op_logical <= sel_logical;
      end else if (state == MASK && op_logical) begin
         mask       <= ~(sh_out << 1);
      end
   end
`endif

   assign bus.req0_ready = !rst && accept && !sel;
   assign bus.req1_ready = !rst && accept && sel;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_data   = rsp_data;
   assign bus.rsp_id     = op_id;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: vector table of single ops plus round-robin, hold and mid-op reset sequences.
module tb_shift_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shift_arbiter_if bus ();
   shift_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef SHIFT_ARB_LOGICAL_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic [4:0]  amt;
      logic        lg;
      logic [31:0] exp_ar;
      logic [31:0] exp_lg;
   } vec_t;

   vec_t vecs [7];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic id, input logic [31:0] d, input logic [4:0] a, input logic lg);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_amt = a; bus.req1_logical = lg;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_amt = a; bus.req0_logical = lg;
      end
   endtask

   task automatic scramble();
      bus.req0_valid = 1'b0; bus.req0_data = 32'h5555_5555; bus.req0_amt = 5'd7; bus.req0_logical = 1'b1;
      bus.req1_valid = 1'b0; bus.req1_data = 32'hAAAA_AAAA; bus.req1_amt = 5'd9; bus.req1_logical = 1'b1;
   endtask

   // Waits (bounded) for rsp_valid, sampling on negedges; returns cycles waited.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 10) begin
         @(negedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] exp;
      int          lat;
      bit          lg_eff;
      lg_eff = LOG_EN && v.lg;
      exp    = lg_eff ? v.exp_lg : v.exp_ar;
      @(negedge clk);
      drive(v.id, v.data, v.amt, v.lg);
      #1;
      check($sformatf("v%0d_ready_own", idx), 32'(v.id ? bus.req1_ready : bus.req0_ready), 32'd1);
      check($sformatf("v%0d_ready_other", idx), 32'(v.id ? bus.req0_ready : bus.req1_ready), 32'd0);
      @(posedge clk); #1;
      scramble();
      wait_rsp(lat);
      check($sformatf("v%0d_latency", idx), 32'(lat), lg_eff ? 32'd3 : 32'd2);
      check($sformatf("v%0d_data", idx), bus.rsp_data, exp);
      check($sformatf("v%0d_id", idx), 32'(bus.rsp_id), 32'(v.id));
      @(negedge clk); #1;
      check($sformatf("v%0d_idle", idx), 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int          lat;
      int          n;
      logic        g;
      logic [31:0] held;
      bit          saw_rsp;

      vecs[0] = '{1'b0, 32'hF000_0000, 5'd4,  1'b0, 32'hFF00_0000, 32'hFF00_0000};
      vecs[1] = '{1'b1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[2] = '{1'b1, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[4] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[5] = '{1'b1, 32'h7FFF_FFFF, 5'd8,  1'b0, 32'h007F_FFFF, 32'h007F_FFFF};
      vecs[6] = '{1'b0, 32'hF0F0_0000, 5'd4,  1'b1, 32'hFF0F_0000, 32'h0F0F_0000};

      scramble();
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      #12;
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ready0", 32'(bus.req0_ready), 32'd0);
      check("rst_ready1", 32'(bus.req1_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_vec(vecs[i], i);

      // Round robin from reset with both requesters always valid.
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      drive(1'b0, 32'h0000_0010, 5'd1, 1'b0);
      drive(1'b1, 32'h0000_0010, 5'd1, 1'b0);
      g = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n = 0;
         while (!(bus.req0_ready || bus.req1_ready) && n < 10) begin
            @(negedge clk); #1;
            n++;
         end
         check($sformatf("rr%0d_ready0", k), 32'(bus.req0_ready), 32'(g == 1'b0));
         check($sformatf("rr%0d_ready1", k), 32'(bus.req1_ready), 32'(g == 1'b1));
         @(posedge clk); #1;
         wait_rsp(lat);
         check($sformatf("rr%0d_lat", k), 32'(lat), 32'd2);
         check($sformatf("rr%0d_id", k), 32'(bus.rsp_id), 32'(g));
         check($sformatf("rr%0d_data", k), bus.rsp_data, 32'h0000_0008);
         @(negedge clk);
         g = ~g;
      end
      scramble();

      // Response held under backpressure while req1 waits.
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      drive(1'b0, 32'h1234_5678, 5'd4, 1'b0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      drive(1'b1, 32'hFFFF_0000, 5'd16, 1'b0);
      wait_rsp(lat);
      check("hold_first_data", bus.rsp_data, 32'h0123_4567);
      held = bus.rsp_data;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         check($sformatf("hold%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
         check($sformatf("hold%0d_data", c), bus.rsp_data, held);
         check($sformatf("hold%0d_id", c), 32'(bus.rsp_id), 32'd0);
         check($sformatf("hold%0d_ready1", c), 32'(bus.req1_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk); #1;
      check("hold_release_ready1", 32'(bus.req1_ready), 32'd1);
      check("hold_release_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      scramble();
      wait_rsp(lat);
      check("hold_second_data", bus.rsp_data, 32'hFFFF_FFFF);
      check("hold_second_id", 32'(bus.rsp_id), 32'd1);
      @(negedge clk);

      // Reset while the op is in SHIFT.
      drive(1'b1, 32'h8000_0000, 5'd3, 1'b0);
      @(posedge clk); #1;
      scramble();
      @(negedge clk);
      check("midrst_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midrst_rsp_data", bus.rsp_data, 32'd0);
      check("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_rsp = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         if (bus.rsp_valid) saw_rsp = 1'b1;
      end
      check("midrst_no_rsp", 32'(saw_rsp), 32'd0);
      @(negedge clk);
      drive(1'b0, 32'h0000_0100, 5'd2, 1'b0);
      drive(1'b1, 32'hFFFF_FFFF, 5'd2, 1'b0);
      #1;
      check("midrst_tie_ready0", 32'(bus.req0_ready), 32'd1);
      check("midrst_tie_ready1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); #1;
      scramble();
      wait_rsp(lat);
      check("midrst_tie_data", bus.rsp_data, 32'h0000_0040);
      check("midrst_tie_id", 32'(bus.rsp_id), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
